// File: rtl/tsm_pkg.sv
// Shared types and constants for the self-test status monitor.
package tsm_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } tsm_state_e;

  localparam int REG_IDX_W = 5;
  localparam int PASS_VAL  = 1;
  // The self-test programs signal completion by writing this value to the done register.
  localparam int DONE_VAL  = 1;

endpackage

// File: rtl/tsm_sat_counter.sv
// Saturating up-counter with synchronous reset, clear and enable.
module tsm_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/test_status_monitor.sv
// Self-test status monitor: snoops register write-back and issues a sticky PASS/FAIL/TIMEOUT verdict.
// Optional feature macro: TSM_PC_TRACE_EN (capture PC of the done write, report failing runs).
module test_status_monitor
  import tsm_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DONE_REG       = 26,
  parameter int RESULT_REG     = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [XLEN-1:0]      testnum_o,
  output logic [CNT_W-1:0]     cycle_cnt_o,
  output logic [XLEN-1:0]      done_pc_o
);

  tsm_state_e       state_reg, state_next;
  logic             active;
  logic             wr_valid;
  logic             done_wr;
  logic             settle_start;
  logic [1:0]       shadow_hit;
  logic [XLEN-1:0]  result_now;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] settle_cnt;

  assign active   = (state_reg == ST_RUN) || (state_reg == ST_SETTLE);
  assign wr_valid = wb_we_i && (wb_addr_i != '0);
  assign done_wr  = wr_valid && (wb_addr_i == REG_IDX_W'(DONE_REG))
                    && (wb_data_i == XLEN'(DONE_VAL));

  // Shadow 0 tracks the result register, shadow 1 the test number.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_shadow
      localparam int IDX = (gi == 0) ? RESULT_REG : TESTNUM_REG;
      logic [XLEN-1:0] value_reg;

      assign shadow_hit[gi] = wr_valid && (wb_addr_i == REG_IDX_W'(IDX));

      always_ff @(posedge clk) begin
        if (rest) begin
          value_reg <= '0;
        end else if (active && shadow_hit[gi]) begin
          value_reg <= wb_data_i;
        end
      end
    end
  endgenerate

  // A result write landing in the final settle cycle still counts toward the verdict.
  assign result_now = shadow_hit[0] ? wb_data_i : g_shadow[0].value_reg;

  tsm_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk  (clk),
    .srst (rest),
    .clr  (1'b0),
    .en   (active),
    .cnt  (cycle_cnt)
  );

  tsm_sat_counter #(.W(CNT_W)) u_settle_cnt (
    .clk  (clk),
    .srst (rest),
    .clr  (settle_start),
    .en   (state_reg == ST_SETTLE),
    .cnt  (settle_cnt)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    settle_start = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (done_wr) begin
          state_next   = ST_SETTLE;
          settle_start = 1'b1;
        end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_next = (result_now == XLEN'(PASS_VAL)) ? ST_PASS : ST_FAIL;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  assign pass_o      = (state_reg == ST_PASS);
  assign fail_o      = (state_reg == ST_FAIL);
  assign timeout_o   = (state_reg == ST_TIMEOUT);
  assign done_o      = pass_o | fail_o | timeout_o;
  assign testnum_o   = g_shadow[1].value_reg;
  assign cycle_cnt_o = cycle_cnt;

`ifdef TSM_PC_TRACE_EN
  logic [XLEN-1:0] done_pc_reg;

  always_ff @(posedge clk) begin
    if (rest) begin
      done_pc_reg <= '0;
    end else if (settle_start) begin
      done_pc_reg <= pc_i;
    end
  end

  assign done_pc_o = done_pc_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rest && active && ((state_next == ST_FAIL) || (state_next == ST_TIMEOUT))) begin
      $display("tsm: %s test=%0d cycle=%0d pc=%h",
               (state_next == ST_FAIL) ? "fail" : "timeout",
               g_shadow[1].value_reg, cycle_cnt, done_pc_reg);
    end
  end
`endif
`else
  logic unused_pc;
  assign unused_pc = ^pc_i;
  assign done_pc_o = '0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed self-checking bench for test_status_monitor (default parameters).
module tb_test_status_monitor;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [31:0] pc_i = '0;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] testnum_o, cycle_cnt_o, done_pc_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  test_status_monitor dut (
    .clk         (clk),
    .rest        (rest),
    .wb_we_i     (wb_we_i),
    .wb_addr_i   (wb_addr_i),
    .wb_data_i   (wb_data_i),
    .pc_i        (pc_i),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .testnum_o   (testnum_o),
    .cycle_cnt_o (cycle_cnt_o),
    .done_pc_o   (done_pc_o)
  );

  function automatic logic [31:0] exp_pc(input logic [31:0] v);
`ifdef TSM_PC_TRACE_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Verdict vector is {done, pass, fail, timeout}.
  task automatic check_verdict(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, done_o, pass_o, fail_o, timeout_o}, {60'd0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_reset();
    rest    = 1'b1;
    wb_we_i = 1'b0;
    @(negedge clk);
    rest = 1'b0;
    cyc  = 0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] pc,
                          input logic we = 1'b1);
    wb_we_i   = we;
    wb_addr_i = addr;
    wb_data_i = data;
    pc_i      = pc;
    $display("cycle %0d: we=%0b x%0d <= %0h pc=%0h", cyc, we, addr, data, pc);
    step(1);
    wb_we_i = 1'b0;
  endtask

  task automatic pass_seq(input string tag);
    wb_write(5'd3, 32'd5, 32'h0);
    check({tag, "_testnum_next"}, 64'(testnum_o), 64'd5);
    wb_write(5'd27, 32'd1, 32'h0);
    step_to(8);
    wb_write(5'd26, 32'd1, 32'h80);
    step_to(18);
    check_verdict({tag, "_settle_last"}, 4'b0000);
    step(1);
    check_verdict({tag, "_pass_c19"}, 4'b1100);
    check({tag, "_testnum"}, 64'(testnum_o), 64'd5);
    check({tag, "_cycle_cnt"}, 64'(cycle_cnt_o), 64'd19);
    check({tag, "_done_pc"}, 64'(done_pc_o), 64'(exp_pc(32'h80)));
  endtask

  initial begin
    // Reset state
    do_reset();
    check_verdict("reset_verdict", 4'b0000);
    check("reset_testnum", 64'(testnum_o), 64'd0);
    check("reset_cycle_cnt", 64'(cycle_cnt_o), 64'd0);
    check("reset_done_pc", 64'(done_pc_o), 64'd0);

    // Basic pass, then writes after the verdict must be ignored
    pass_seq("pass1");
    wb_write(5'd3, 32'd9, 32'h0);
    wb_write(5'd27, 32'd0, 32'h0);
    wb_write(5'd26, 32'd1, 32'h200);
    step(2);
    check_verdict("post_verdict_verdict", 4'b1100);
    check("post_verdict_testnum", 64'(testnum_o), 64'd5);
    check("post_verdict_cycle_cnt", 64'(cycle_cnt_o), 64'd19);
    check("post_verdict_done_pc", 64'(done_pc_o), 64'(exp_pc(32'h80)));

    // Fail: result 0, done at cycle 1 -> verdict at cycle 12
    do_reset();
    wb_write(5'd27, 32'd0, 32'h0);
    wb_write(5'd26, 32'd1, 32'h100);
    step_to(11);
    check_verdict("fail_settle_last", 4'b0000);
    step(1);
    check_verdict("fail_verdict", 4'b1010);
    check("fail_done_pc", 64'(done_pc_o), 64'(exp_pc(32'h100)));

    // Result written inside SETTLE
    do_reset();
    wb_write(5'd26, 32'd1, 32'h0);
    step_to(3);
    wb_write(5'd27, 32'd1, 32'h0);
    step_to(11);
    check_verdict("late_result_pass", 4'b1100);

    // Result written in the final settle cycle still counts
    do_reset();
    wb_write(5'd26, 32'd1, 32'h0);
    step_to(10);
    check_verdict("last_cycle_pending", 4'b0000);
    wb_write(5'd27, 32'd1, 32'h0);
    check_verdict("last_cycle_result_pass", 4'b1100);

    // Done register written with a non-1 value, x0 writes, and writes without enable
    do_reset();
    wb_write(5'd26, 32'd2, 32'h0);
    wb_write(5'd0, 32'd1, 32'h0);
    wb_write(5'd3, 32'd7, 32'h0, 1'b0);
    step_to(15);
    check_verdict("bad_done_stays_run", 4'b0000);
    check("ignored_writes_testnum", 64'(testnum_o), 64'd0);
    check("run_cycle_cnt", 64'(cycle_cnt_o), 64'd15);

    // Timeout with no done write
    do_reset();
    step_to(49);
    check_verdict("timeout_c49", 4'b0000);
    step(1);
    check_verdict("timeout_c50", 4'b1001);
    check("timeout_cycle_cnt", 64'(cycle_cnt_o), 64'd50);
    step(5);
    check("timeout_cnt_frozen", 64'(cycle_cnt_o), 64'd50);

    // Done write in cycle 49 beats the timeout
    do_reset();
    step_to(49);
    wb_write(5'd26, 32'd1, 32'h0);
    check_verdict("done_c49_no_timeout", 4'b0000);
    step_to(59);
    check_verdict("done_c49_settle_last", 4'b0000);
    step(1);
    check_verdict("done_c49_fail", 4'b1010);
    check("done_c49_cycle_cnt", 64'(cycle_cnt_o), 64'd60);

    // Reset in the middle of SETTLE, then a full pass with unchanged timing
    do_reset();
    wb_write(5'd3, 32'd7, 32'h0);
    wb_write(5'd26, 32'd1, 32'h44);
    step_to(5);
    check("midsettle_testnum", 64'(testnum_o), 64'd7);
    rest = 1'b1;
    @(negedge clk);
    check_verdict("midsettle_rst_verdict", 4'b0000);
    check("midsettle_rst_testnum", 64'(testnum_o), 64'd0);
    check("midsettle_rst_cycle_cnt", 64'(cycle_cnt_o), 64'd0);
    check("midsettle_rst_done_pc", 64'(done_pc_o), 64'd0);
    rest = 1'b0;
    cyc  = 0;
    pass_seq("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
# test_status_monitor

Synthesizable self-test status monitor for the RV32 core. It snoops the register-file write-back port, tracks the done, result and test-number registers used by the self-test programs, and issues a sticky PASS/FAIL/TIMEOUT verdict after a programmable settle window. It is instantiated beside `cpu_core` inside `cpu_top`, so the same verdict logic serves both simulation benches and FPGA bring-up (verdict driven to LEDs/UART).

## Interface
Parameters:
- `XLEN`, 32, data width of the write-back port
- `DONE_REG`, 26, register index whose write of value 1 signals program end
- `RESULT_REG`, 27, register index holding the result (1 = pass)
- `TESTNUM_REG`, 3, register index holding the current test number
- `SETTLE_CYCLES`, 10, cycles (≥1) waited after done before the verdict
- `TIMEOUT_CYCLES`, 50, cycles after reset release before a TIMEOUT verdict, if done has not arrived
- `CNT_W`, 32, width of the cycle counter

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rest`  in  1  synchronous, active-high reset
- `wb_we_i`  in  1  register-file write enable
- `wb_addr_i`  in  5  register-file write index
- `wb_data_i`  in  XLEN  register-file write data
- `pc_i`  in  XLEN  PC of the instruction being written back
- `done_o`  out  1  a verdict has been reached (sticky)
- `pass_o`  out  1  verdict is PASS (sticky)
- `fail_o`  out  1  verdict is FAIL (sticky)
- `timeout_o`  out  1  verdict is TIMEOUT (sticky)
- `testnum_o`  out  XLEN  last value written to TESTNUM_REG
- `cycle_cnt_o`  out  CNT_W  cycles elapsed since reset release
- `done_pc_o`  out  XLEN  PC of the done-triggering write (see Configuration)

## Operation
- Reset value of all outputs: 0. Shadow registers are cleared to 0 and the state machine is in RUN.
- Shadows: a write with `wb_we_i`=1 and `wb_addr_i` equal to RESULT_REG or TESTNUM_REG updates the matching shadow. Writes with `wb_addr_i`=0 are ignored.
- States:
  - RUN:
    - A write to DONE_REG with data equal to 1 moves the monitor to SETTLE and clears `settle_cnt`.
    - A write to DONE_REG with any other data is ignored.
    - If `cycle_cnt`==TIMEOUT_CYCLES-1 and no done write occurs in that cycle, the monitor moves to TIMEOUT.
    - A done write in that same cycle wins and moves the monitor to SETTLE.
  - SETTLE:
    - Shadows keep updating and `settle_cnt` increments.
    - When `settle_cnt`==SETTLE_CYCLES-1, the monitor moves to PASS if the result shadow equals 1 (including a result write sampled in that same cycle), otherwise to FAIL.
    - Timeout is not evaluated in SETTLE.
  - PASS, FAIL, TIMEOUT: terminal. Shadows and counters freeze, and snooped writes are ignored until `rest` is asserted.
- `cycle_cnt_o` increments in RUN and SETTLE and saturates at all-ones.
- `done_o` equals pass_o | fail_o | timeout_o. Exactly one verdict bit is high in a terminal state.
- Asserting `rest` in any state, including mid-SETTLE, returns the block to the reset values on the next edge.

## Timing
- Shadow updates are visible on outputs the cycle after the write is sampled.
- A done write sampled at edge T gives SETTLE during cycles T+1 … T+SETTLE_CYCLES. The verdict is high from cycle T+SETTLE_CYCLES+1.
- Counting the first cycle after reset release as cycle 0, `timeout_o` rises in cycle TIMEOUT_CYCLES.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `TSM_PC_TRACE_EN` defined:
  - `done_pc_o` captures `pc_i` on the done-triggering write and holds it until reset.
  - On entering FAIL or TIMEOUT, a simulation-only `$display` prints the test number, cycle count and captured PC.
- `TSM_PC_TRACE_EN` undefined: `done_pc_o` is tied to 0, `pc_i` is unused, and no display is generated.

## Structure
- Package `tsm_pkg` holds:
  - the state enum (RUN, SETTLE, PASS, FAIL, TIMEOUT)
  - the register-index width constant (5)
  - the pass-value constant (1)
- Sub-module `tsm_sat_counter`: a parametrised-width saturating counter with clear and enable inputs. It is used for both `cycle_cnt` and `settle_cnt`.

## Test plan
- Write x3=5, then x27=1, then x26=1 at cycle 8, with SETTLE_CYCLES=10 → `pass_o`=1 from cycle 19, `testnum_o`=5, `fail_o`=`timeout_o`=0.
- Write x27=0, then x26=1 → `fail_o`=1 after the settle window. With TSM_PC_TRACE_EN, `done_pc_o` equals the PC presented with the x26 write.
- Write x26=1, then x27=1 three cycles later (inside SETTLE) → `pass_o`=1. Write x26=2 alone → monitor stays in RUN.
- No done write with TIMEOUT_CYCLES=50 → `timeout_o`=1 in cycle 50 and `cycle_cnt_o` freezes at 50. Done write in cycle 49 → SETTLE, no timeout.
- Writes to x0, and any writes after a verdict → no effect on shadows or outputs.
- Assert `rest` midway through SETTLE → all outputs 0 next cycle. A subsequent full pass sequence yields PASS with the same timing.
